// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit_pkg
//  Purpose  : Shared definitions for the fetch unit and the decoder:
//             fetch FSM state encoding, NOP/HALT opcodes and the PC
//             increment helper (8-bit, wraps FF -> 00).
//  Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam int          c_ADDR_W      = 8;
    localparam logic [7:0]  c_NOP_OPCODE  = 8'h00;
    localparam logic [7:0]  c_HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Natural 8-bit overflow gives the FF -> 00 wrap with no flag.
    function automatic logic [c_ADDR_W-1:0] next_pc(input logic [c_ADDR_W-1:0] pc);
        return pc + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
//  Module   : pc_register
//  Purpose  : 8-bit program counter with load / increment / hold.
//             Load has priority over increment; neither means hold.
//  Ports    : clk_i        - clock
//             reset_i      - asynchronous active-high reset (pc <= RESET_PC)
//             load_i       - load load_addr_i
//             load_addr_i  - redirect address
//             inc_i        - advance to the next sequential address (wraps)
//             pc_o         - current program counter
//  Revision : 1.0 - initial release
// ============================================================================
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] load_addr_i,
    input  logic       inc_i,
    output logic [7:0] pc_o
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = next_pc(pc_q);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Purpose  : Sequential requester for a 256x8 combinational instruction
//             memory. Drives the address from the PC, registers the returned
//             byte into the IR with its address and a valid flag, and handles
//             stall, branch redirect/flush, HALT detection and a saturating
//             fetch counter.
//  Ports    : clk_i            - clock, rising edge
//             reset_i          - asynchronous active-high reset
//             enable_i         - start fetching (sampled in IDLE only)
//             stall_i          - hold PC, IR and counter
//             branch_en_i      - redirect PC and flush IR (beats stall)
//             branch_target_i  - redirect address
//             imem_addr_o      - memory address (= PC, unregistered)
//             imem_instr_i     - memory data for imem_addr_o
//             instr_out_o      - IR contents
//             instr_pc_o       - address the IR contents came from
//             instr_valid_o    - IR holds a real fetched instruction
//             halted_o         - unit is halted
//             fetch_count_o    - valid captures so far, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] NOP_OPCODE  = c_NOP_OPCODE,
    parameter logic [7:0] HALT_OPCODE = c_HALT_OPCODE,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             stall_i,
    input  logic             branch_en_i,
    input  logic [7:0]       branch_target_i,
    output logic [7:0]       imem_addr_o,
    input  logic [7:0]       imem_instr_i,
    output logic [7:0]       instr_out_o,
    output logic [7:0]       instr_pc_o,
    output logic             instr_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    fetch_state_t     state_q;
    logic [7:0]       instr_q;
    logic [7:0]       instr_pc_q;
    logic             valid_q;
    logic             halted_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [7:0]       pc_w;
    logic             pc_load_w;
    logic             pc_inc_w;

    // PC only moves in RUN; a branch overrides a simultaneous stall.
    assign pc_load_w = (state_q == ST_RUN) && branch_en_i;
    assign pc_inc_w  = (state_q == ST_RUN) && !branch_en_i && !stall_i;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (pc_load_w),
        .load_addr_i (branch_target_i),
        .inc_i       (pc_inc_w),
        .pc_o        (pc_w)
    );

    // Saturating increment: an all-ones counter stays all-ones.
    assign count_d = (&count_q) ? count_q
                                : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            instr_q    <= NOP_OPCODE;
            instr_pc_q <= 8'h00;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The entry edge into RUN captures nothing.
                    valid_q <= 1'b0;
                    if (enable_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (branch_en_i) begin
                        // Flush: drop the instruction currently addressed;
                        // instr_pc keeps the last real fetch address.
                        instr_q <= NOP_OPCODE;
                        valid_q <= 1'b0;
                    end else if (!stall_i) begin
                        instr_q    <= imem_instr_i;
                        instr_pc_q <= pc_w;
                        valid_q    <= 1'b1;
                        count_q    <= count_d;
                        // HALT is still presented as valid for one cycle.
                        if (imem_instr_i == HALT_OPCODE) begin
                            state_q <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_addr_o   = pc_w;
    assign instr_out_o   = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_unit
//  Purpose  : Self-checking bench for instruction_fetch_unit. A second
//             instance with a 4-bit counter shares all inputs so counter
//             saturation is observable in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        branch_en;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr,  imem_addr4;
    logic [7:0]  imem_instr, imem_instr4;
    logic [7:0]  instr_out,  instr_out4;
    logic [7:0]  instr_pc,   instr_pc4;
    logic        instr_valid, instr_valid4;
    logic        halted,     halted4;
    logic [15:0] fetch_count;
    logic [3:0]  fetch_count4;

    logic [7:0]  mem [0:255];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the unit.
    int          m_mode;   // 0 idle, 1 fetching, 2 halted
    logic [7:0]  m_pc, m_ir, m_irpc;
    logic        m_valid, m_halted;
    int          m_cnt, m_cnt4;

    always #5 clk = ~clk;

    assign imem_instr  = mem[imem_addr];
    assign imem_instr4 = mem[imem_addr4];

    instruction_fetch_unit #(.CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .stall_i(stall),
        .branch_en_i(branch_en), .branch_target_i(branch_target),
        .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .instr_out_o(instr_out), .instr_pc_o(instr_pc),
        .instr_valid_o(instr_valid), .halted_o(halted),
        .fetch_count_o(fetch_count)
    );

    instruction_fetch_unit #(.CNT_W(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .stall_i(stall),
        .branch_en_i(branch_en), .branch_target_i(branch_target),
        .imem_addr_o(imem_addr4), .imem_instr_i(imem_instr4),
        .instr_out_o(instr_out4), .instr_pc_o(instr_pc4),
        .instr_valid_o(instr_valid4), .halted_o(halted4),
        .fetch_count_o(fetch_count4)
    );

    function automatic logic [45:0] dut_vec();
        return {imem_addr, instr_out, instr_pc, instr_valid, halted,
                fetch_count, fetch_count4};
    endfunction

    function automatic logic [45:0] model_vec();
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = m_cnt[15:0];
        c4  = m_cnt4[3:0];
        return {m_pc, m_ir, m_irpc, m_valid, m_halted, c16, c4};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 8'h00; m_ir = 8'h00; m_irpc = 8'h00;
        m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0; m_cnt4 = 0;
    endtask

    // One rising edge of the specified behaviour, using the inputs in force.
    task automatic model_step();
        if (m_mode == 0) begin
            if (enable) m_mode = 1;
        end else if (m_mode == 1) begin
            if (branch_en) begin
                m_pc = branch_target; m_ir = 8'h00; m_valid = 1'b0;
            end else if (!stall) begin
                m_ir    = mem[m_pc];
                m_irpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = 8'((int'(m_pc) + 1) % 256);
                m_cnt   = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
                m_cnt4  = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
                if (m_ir == 8'hFF) m_mode = 2;
            end
        end else begin
            m_valid = 1'b0; m_halted = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic fill_mem(input bit allow_halt);
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
            if (mem[a] == 8'hFF && !allow_halt) mem[a] = 8'h3C;
            if (allow_halt && $urandom_range(0, 15) == 0) mem[a] = 8'hFF;
        end
    endtask

    task automatic do_reset();
        enable = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== model_vec() || fetch_count !== 16'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
        end
        repeat (3) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_idle_hold got=%h exp=%h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_halt_program();
        do_reset();
        fill_mem(0);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFF;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            enable = 1'b0;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL halt_seq cyc=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd3 ||
            imem_addr !== 8'h03 || instr_out !== 8'hFF || instr_pc !== 8'h02) begin
            errors++;
            $display("FAIL halt_final got h=%b v=%b cnt=%0d addr=%h ir=%h ipc=%h exp h=1 v=0 cnt=3 addr=03 ir=ff ipc=02",
                     halted, instr_valid, fetch_count, imem_addr, instr_out, instr_pc);
        end
        // Inputs must be ignored once halted.
        branch_en = 1'b1; branch_target = 8'h80; enable = 1'b1;
        cyc();
        branch_en = 1'b0; enable = 1'b0;
        checks++;
        if (dut_vec() !== model_vec() || imem_addr !== 8'h03) begin
            errors++;
            $display("FAIL halt_ignore got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_stall();
        do_reset();
        fill_mem(0);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        enable = 1'b1;
        cyc(); cyc(); cyc();   // idle edge, capture 0, capture 1
        enable = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec() || instr_out !== 8'h22 || instr_pc !== 8'h01 ||
                imem_addr !== 8'h02 || fetch_count !== 16'd2) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (dut_vec() !== model_vec() || instr_pc !== 8'h02 || instr_out !== 8'h33) begin
            errors++;
            $display("FAIL stall_resume got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_branch();
        do_reset();
        fill_mem(0);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        repeat (5) cyc();      // captures 0..4, pc now 5
        checks++;
        if (dut_vec() !== model_vec() || imem_addr !== 8'h05) begin
            errors++;
            $display("FAIL branch_pre got=%h exp=%h", dut_vec(), model_vec());
        end
        branch_en = 1'b1; branch_target = 8'h40; stall = 1'b1;
        cyc();
        branch_en = 1'b0; stall = 1'b0;
        checks++;
        if (dut_vec() !== model_vec() || instr_out !== 8'h00 || instr_valid !== 1'b0 ||
            imem_addr !== 8'h40 || instr_pc !== 8'h04) begin
            errors++;
            $display("FAIL branch_flush got=%h exp=%h", dut_vec(), model_vec());
        end
        cyc();
        checks++;
        if (dut_vec() !== model_vec() || instr_pc !== 8'h40 || instr_out !== mem[8'h40]) begin
            errors++;
            $display("FAIL branch_target got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_wrap();
        branch_en = 1'b1; branch_target = 8'hFE;
        cyc();
        branch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (k == 1) begin
                checks++;
                if (instr_pc !== 8'hFF || imem_addr !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_addr got ipc=%h addr=%h exp ipc=ff addr=00", instr_pc, imem_addr);
                end
            end
        end
        checks++;
        if (instr_pc !== 8'h00 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_capture got ipc=%h v=%b exp ipc=00 v=1", instr_pc, instr_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_mem(0);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        branch_en = 1'b1; branch_target = 8'h35;
        cyc();
        branch_en = 1'b0;
        cyc(); cyc();
        checks++;
        if (dut_vec() !== model_vec() || imem_addr !== 8'h37) begin
            errors++;
            $display("FAIL async_pre got=%h exp=%h", dut_vec(), model_vec());
        end
        @(posedge clk);
        model_step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (imem_addr !== 8'h00 || instr_out !== 8'h00 || instr_valid !== 1'b0 ||
            halted !== 1'b0 || fetch_count !== 16'h0 || instr_pc !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL async_idle cyc=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        cyc();
        checks++;
        if (dut_vec() !== model_vec() || instr_pc !== 8'h00 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_restart got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        fill_mem(0);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL sat cyc=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        checks++;
        if (fetch_count4 !== 4'hF || fetch_count !== 16'd20) begin
            errors++;
            $display("FAIL sat_final got c4=%h c16=%0d exp c4=f c16=20", fetch_count4, fetch_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 0) begin
                reset = 1'b1;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
                fill_mem(1);
            end
            enable        = 1'($urandom_range(0, 1));
            stall         = ($urandom_range(0, 3) == 0);
            branch_en     = ($urandom_range(0, 9) == 0);
            branch_target = 8'($urandom);
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        enable = 1'b0; stall = 1'b0; branch_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; stall = 1'b0;
        branch_en = 1'b0; branch_target = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        model_reset();
        test_reset();
        test_halt_program();
        test_stall();
        test_branch();
        test_wrap();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
